// File: rtl/kernel_launcher_pkg.sv
// Shared types for the kernel launcher: host data word and the configuration
// record handed to the block dispatcher.
package kernel_launcher_pkg;

    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        data_t       arg_ptr;
        logic [15:0] block_dim;
        data_t       num_blocks;
    } kernel_config_t;

endpackage

// File: rtl/kernel_launcher_if.sv
// Host register bus between the host (master) and the kernel launcher (slave).
interface kernel_launcher_if;
    import kernel_launcher_pkg::*;

    logic        host_wr_en;
    logic        host_rd_en;
    logic [2:0]  host_addr;
    data_t       host_wr_data;
    data_t       host_rd_data;
    logic        host_rd_valid;

    modport master (
        output host_wr_en, host_rd_en, host_addr, host_wr_data,
        input  host_rd_data, host_rd_valid
    );

    modport slave (
        input  host_wr_en, host_rd_en, host_addr, host_wr_data,
        output host_rd_data, host_rd_valid
    );

endinterface

// File: rtl/kernel_launcher.sv
// Host-programmed kernel launcher: register file, launch FSM (reset then start
// the dispatcher), completion/watchdog tracking and completion interrupt.
module kernel_launcher
    import kernel_launcher_pkg::*;
#(
    parameter int WATCHDOG_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    kernel_launcher_if.slave host,
    output kernel_config_t   kernel_config,
    output logic             dispatch_reset,
    output logic             dispatch_start,
    input  logic             dispatch_done,
    output logic             irq
);

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_NBLK   = 3'd1;
    localparam logic [2:0] ADDR_STATUS = 3'd2;
    localparam logic [2:0] ADDR_CYCLES = 3'd3;
    localparam logic [2:0] ADDR_LCOUNT = 3'd4;
    localparam data_t      WD_LAST     = data_t'(WATCHDOG_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_DRAIN,
        S_ABORT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic  r_irq_en;
    data_t r_num_blocks;
    data_t r_shadow;
    logic  r_done;
    logic  r_zero_err;
    logic  r_busy_err;
    logic  r_wd_err;
    data_t r_cycle_count;
    data_t r_launch_count;
    data_t r_rd_data;
    logic  r_rd_valid;

    logic  w_ctrl_wr;
    logic  w_launch;
    logic  w_clear;
    logic  w_idle;
    logic  w_accept;
    logic  w_wd_expire;
    data_t w_rd_mux;

    function automatic data_t sat_inc(input data_t v);
        return (&v) ? v : v + data_t'(1);
    endfunction

    assign w_ctrl_wr   = host.host_wr_en && (host.host_addr == ADDR_CTRL);
    assign w_launch    = w_ctrl_wr && host.host_wr_data[0];
    assign w_clear     = w_ctrl_wr && host.host_wr_data[1];
    assign w_idle      = (r_state == S_IDLE);
    assign w_accept    = w_launch && w_idle && (r_num_blocks != '0);
    assign w_wd_expire = (WATCHDOG_CYCLES != 0) && (r_cycle_count == WD_LAST) && !dispatch_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // dispatch_reset is forced high while our own reset is asserted so the
    // dispatcher comes out of reset together with the launcher.
    always_comb begin
        w_next         = r_state;
        dispatch_reset = reset;
        dispatch_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_PREP;
            end
            S_PREP: begin
                dispatch_reset = 1'b1;
                w_next         = S_RUN;
            end
            S_RUN: begin
                dispatch_start = 1'b1;
                if (dispatch_done)    w_next = S_DRAIN;
                else if (w_wd_expire) w_next = S_ABORT;
            end
            S_DRAIN: begin
                w_next = S_IDLE;
            end
            S_ABORT: begin
                dispatch_reset = 1'b1;
                w_next         = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Later assignments override earlier ones: clear_status first, then the
    // launch evaluation and set events, so a set always beats a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_en       <= 1'b0;
            r_num_blocks   <= '0;
            r_shadow       <= '0;
            r_done         <= 1'b0;
            r_zero_err     <= 1'b0;
            r_busy_err     <= 1'b0;
            r_wd_err       <= 1'b0;
            r_cycle_count  <= '0;
            r_launch_count <= '0;
            r_rd_data      <= '0;
            r_rd_valid     <= 1'b0;
        end else begin
            r_rd_valid <= host.host_rd_en;
            r_rd_data  <= host.host_rd_en ? w_rd_mux : '0;

            if (w_ctrl_wr) r_irq_en <= host.host_wr_data[2];
            if (host.host_wr_en && (host.host_addr == ADDR_NBLK) && w_idle)
                r_num_blocks <= host.host_wr_data;

            if (w_clear) begin
                r_done     <= 1'b0;
                r_zero_err <= 1'b0;
                r_busy_err <= 1'b0;
                r_wd_err   <= 1'b0;
            end

            if (w_accept) begin
                r_done         <= 1'b0;
                r_cycle_count  <= '0;
                r_launch_count <= r_launch_count + data_t'(1);
                r_shadow       <= r_num_blocks;
            end
            if (w_launch && w_idle && (r_num_blocks == '0)) r_zero_err <= 1'b1;
            if (w_launch && !w_idle)                        r_busy_err <= 1'b1;

            if (r_state == S_RUN) begin
                r_cycle_count <= sat_inc(r_cycle_count);
                if (dispatch_done)    r_done   <= 1'b1;
                else if (w_wd_expire) r_wd_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (host.host_addr)
            ADDR_CTRL:   w_rd_mux[2]   = r_irq_en;
            ADDR_NBLK:   w_rd_mux      = r_num_blocks;
            ADDR_STATUS: w_rd_mux[4:0] = {r_wd_err, r_busy_err, r_zero_err, r_done, !w_idle};
            ADDR_CYCLES: w_rd_mux      = r_cycle_count;
            ADDR_LCOUNT: w_rd_mux      = r_launch_count;
            default:     w_rd_mux      = '0;
        endcase
    end

    always_comb begin
        kernel_config            = '0;
        kernel_config.num_blocks = r_shadow;
    end

    assign irq                = r_irq_en & (r_done | r_wd_err);
    assign host.host_rd_data  = r_rd_data;
    assign host.host_rd_valid = r_rd_valid;

endmodule

// File: tb/tb_kernel_launcher.sv
// Bench for kernel_launcher: two instances (watchdog off / watchdog 8) share
// one stimulus stream and are compared every cycle against a behavioural model.
module tb_kernel_launcher;
    import kernel_launcher_pkg::*;

    localparam int M_IDLE = 0, M_PREP = 1, M_RUN = 2, M_DRAIN = 3, M_ABORT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       wr_en = 1'b0, rd_en = 1'b0, done_in = 1'b0;
    logic [2:0] addr  = 3'd0;
    data_t      wdata = '0;

    kernel_launcher_if bus0 ();
    kernel_launcher_if bus1 ();
    assign bus0.host_wr_en = wr_en;  assign bus1.host_wr_en = wr_en;
    assign bus0.host_rd_en = rd_en;  assign bus1.host_rd_en = rd_en;
    assign bus0.host_addr  = addr;   assign bus1.host_addr  = addr;
    assign bus0.host_wr_data = wdata; assign bus1.host_wr_data = wdata;

    kernel_config_t kc0, kc1;
    logic drst0, drst1, dstart0, dstart1, irq0, irq1;

    kernel_launcher #(.WATCHDOG_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .host(bus0.slave), .kernel_config(kc0),
        .dispatch_reset(drst0), .dispatch_start(dstart0), .dispatch_done(done_in), .irq(irq0));
    kernel_launcher #(.WATCHDOG_CYCLES(8)) dut1 (
        .clk(clk), .reset(reset), .host(bus1.slave), .kernel_config(kc1),
        .dispatch_reset(drst1), .dispatch_start(dstart1), .dispatch_done(done_in), .irq(irq1));

    int total = 0, bad = 0;
    int n_rst = 0, n_start = 0;
    bit chk_on = 0, auto_disp = 0;
    logic drst_q = 1'b0, dstart_q = 1'b0;
    int lat = 0;
    data_t rd0, rd1;

    // behavioural model state, one slot per instance
    int    m_st[2];
    data_t m_nb[2], m_sh[2], m_cyc[2], m_lc[2], m_rd[2];
    bit    m_ien[2], m_done[2], m_ze[2], m_be[2], m_we[2], m_rv[2];

    function automatic int wd(input int i);
        return (i == 0) ? 0 : 8;
    endfunction

    task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic data_t mread(input int i, input logic [2:0] a);
        data_t v = '0;
        case (a)
            3'd0: v[2] = m_ien[i];
            3'd1: v = m_nb[i];
            3'd2: v[4:0] = {m_we[i], m_be[i], m_ze[i], m_done[i], m_st[i] != M_IDLE};
            3'd3: v = m_cyc[i];
            3'd4: v = m_lc[i];
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic mstep(input int i);
        data_t rv;
        bit ctrl, launch;
        if (reset) begin
            m_st[i] = M_IDLE; m_nb[i] = '0; m_sh[i] = '0; m_cyc[i] = '0; m_lc[i] = '0;
            m_rd[i] = '0; m_ien[i] = 0; m_done[i] = 0; m_ze[i] = 0; m_be[i] = 0;
            m_we[i] = 0; m_rv[i] = 0;
            return;
        end
        rv      = mread(i, addr);
        m_rv[i] = rd_en;
        m_rd[i] = rd_en ? rv : '0;
        ctrl    = wr_en && (addr == 3'd0);
        launch  = ctrl && wdata[0];
        if (ctrl && wdata[1]) begin
            m_done[i] = 0; m_ze[i] = 0; m_be[i] = 0; m_we[i] = 0;
        end
        if (ctrl) m_ien[i] = wdata[2];
        if (launch && m_st[i] != M_IDLE) m_be[i] = 1;
        case (m_st[i])
            M_IDLE: begin
                if (wr_en && addr == 3'd1) m_nb[i] = wdata;
                if (launch) begin
                    if (m_nb[i] == '0) m_ze[i] = 1;
                    else begin
                        m_done[i] = 0; m_cyc[i] = '0; m_lc[i] = m_lc[i] + 1;
                        m_sh[i] = m_nb[i]; m_st[i] = M_PREP;
                    end
                end
            end
            M_PREP: m_st[i] = M_RUN;
            M_RUN: begin
                if (done_in) begin
                    m_done[i] = 1; m_st[i] = M_DRAIN;
                end else if (wd(i) != 0 && m_cyc[i] == data_t'(wd(i) - 1)) begin
                    m_we[i] = 1; m_st[i] = M_ABORT;
                end
                if (m_cyc[i] != '1) m_cyc[i] = m_cyc[i] + 1;
            end
            default: m_st[i] = M_IDLE;
        endcase
    endtask

    task automatic cmp(input int i);
        kernel_config_t ek;
        ek = '0;
        ek.num_blocks = m_sh[i];
        check($sformatf("dispatch_reset[%0d]", i), (i == 0) ? drst0 : drst1,
              reset || m_st[i] == M_PREP || m_st[i] == M_ABORT);
        check($sformatf("dispatch_start[%0d]", i), (i == 0) ? dstart0 : dstart1, m_st[i] == M_RUN);
        check($sformatf("irq[%0d]", i), (i == 0) ? irq0 : irq1, m_ien[i] & (m_done[i] | m_we[i]));
        check($sformatf("kernel_config[%0d]", i), (i == 0) ? kc0 : kc1, ek);
        check($sformatf("rd_valid[%0d]", i), (i == 0) ? bus0.host_rd_valid : bus1.host_rd_valid, m_rv[i]);
        if (m_rv[i])
            check($sformatf("rd_data[%0d]", i), (i == 0) ? bus0.host_rd_data : bus1.host_rd_data, m_rd[i]);
    endtask

    always @(posedge clk) begin
        mstep(0);
        mstep(1);
    end

    always @(negedge clk) begin
        drst_q   = drst0;
        dstart_q = dstart0;
        if (chk_on) begin
            cmp(0);
            cmp(1);
            if (drst0)   n_rst++;
            if (dstart0) n_start++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_disp) begin
            if (drst_q) begin
                done_in = 1'b0;
                lat     = $urandom_range(0, 12);
            end else if (dstart_q && !done_in) begin
                if (lat == 0) done_in = 1'b1;
                else          lat--;
            end
        end
    endtask

    task automatic wr(input logic [2:0] a, input data_t d);
        wr_en = 1'b1; addr = a; wdata = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        rd_en = 1'b1; addr = a;
        tick();
        rd_en = 1'b0;
        rd0 = bus0.host_rd_data;
        rd1 = bus1.host_rd_data;
    endtask

    task automatic do_reset();
        reset = 1'b1; done_in = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    initial begin
        // reset state
        tick();
        chk_on = 1;
        tick(); tick();
        check("rst dispatch_reset", drst0, 1'b1);
        check("rst dispatch_start", dstart0, 1'b0);
        check("rst irq", irq0, 1'b0);
        check("rst kernel_config", kc0, '0);
        check("rst rd_valid", bus0.host_rd_valid, 1'b0);
        reset = 1'b0;
        tick();

        // zero-block launch
        n_rst = 0; n_start = 0;
        wr(3'd0, 32'h1);
        repeat (3) tick();
        check("zero no reset pulse", n_rst, 0);
        check("zero no start", n_start, 0);
        rd(3'd2); check("zero STATUS", rd0, 32'h4);
        rd(3'd4); check("zero LAUNCH_COUNT", rd0, 32'h0);
        wr(3'd0, 32'h2);
        rd(3'd2); check("clear STATUS", rd0, 32'h0);

        // basic launch, dispatcher done 10 cycles after start rises
        wr(3'd1, 32'd4);
        n_rst = 0; n_start = 0;
        wr(3'd0, 32'h1);
        check("basic PREP reset", drst0, 1'b1);
        check("basic PREP no start", dstart0, 1'b0);
        tick();
        check("basic RUN start", dstart0, 1'b1);
        check("basic RUN no reset", drst0, 1'b0);
        repeat (10) tick();
        done_in = 1'b1;
        tick();
        check("basic DRAIN start low", dstart0, 1'b0);
        rd(3'd2); check("basic DRAIN STATUS", rd0, 32'h3);
        rd(3'd2); check("basic STATUS", rd0, 32'h2);
        check("wd1 basic STATUS", rd1, 32'h10);
        rd(3'd3); check("basic CYCLE_COUNT", rd0, 32'd11);
        rd(3'd4); check("basic LAUNCH_COUNT", rd0, 32'd1);
        check("basic one reset pulse", n_rst, 1);
        check("basic start cycles", n_start, 11);

        // clear/done collision, then back-to-back launch with stale done
        wr(3'd0, 32'h2);
        wr(3'd0, 32'h5);
        tick();
        done_in = 1'b0;
        repeat (2) tick();
        wr_en = 1'b1; addr = 3'd0; wdata = 32'h6; done_in = 1'b1;
        tick();
        wr_en = 1'b0;
        check("collision irq", irq0, 1'b1);
        check("collision DRAIN", dstart0, 1'b0);
        tick();
        wr(3'd0, 32'h5);
        check("b2b PREP reset", drst0, 1'b1);
        check("b2b PREP no start", dstart0, 1'b0);
        check("b2b done cleared", irq0, 1'b0);
        tick();
        done_in = 1'b0;
        check("b2b RUN", dstart0, 1'b1);
        repeat (3) tick();
        rd(3'd3); check("b2b CYCLE_COUNT", rd0, 32'd3);
        rd(3'd4); check("b2b LAUNCH_COUNT", rd0, 32'd3);
        done_in = 1'b1;
        tick(); tick();

        // watchdog on the WATCHDOG_CYCLES=8 instance
        do_reset();
        wr(3'd1, 32'd4);
        wr(3'd0, 32'h5);
        tick();
        repeat (8) tick();
        check("wd ABORT reset", drst1, 1'b1);
        check("wd ABORT no start", dstart1, 1'b0);
        check("wd irq", irq1, 1'b1);
        check("nowd still running", dstart0, 1'b1);
        tick();
        rd(3'd2);
        check("wd STATUS", rd1, 32'h10);
        check("nowd busy STATUS", rd0, 32'h1);
        rd(3'd3); check("wd CYCLE_COUNT", rd1, 32'd8);
        done_in = 1'b1;
        tick(); tick();

        // busy protection, then reset mid-RUN
        do_reset();
        wr(3'd1, 32'd4);
        wr(3'd0, 32'h5);
        tick();
        wr(3'd1, 32'd9);
        wr(3'd0, 32'h1);
        check("busy shadow", kc0.num_blocks, 32'd4);
        rd(3'd1); check("busy NUM_BLOCKS", rd0, 32'd4);
        rd(3'd2); check("busy STATUS", rd0, 32'h9);
        rd(3'd4); check("busy LAUNCH_COUNT", rd0, 32'd1);
        reset = 1'b1;
        tick();
        check("midrun reset dispatch_reset", drst0, 1'b1);
        check("midrun reset start", dstart0, 1'b0);
        check("midrun reset kernel_config", kc0, '0);
        check("midrun reset rd_valid", bus0.host_rd_valid, 1'b0);
        check("midrun reset irq", irq0, 1'b0);
        reset = 1'b0;
        tick();
        rd(3'd1); check("post reset NUM_BLOCKS", rd0, 32'd0);
        rd(3'd4); check("post reset LAUNCH_COUNT", rd0, 32'd0);

        // randomized traffic with a dispatcher that answers after a random delay
        auto_disp = 1;
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] r;
            r     = $urandom;
            reset = (r[8:0] == 9'd0);
            wr_en = (r[11:10] == 2'd0);
            rd_en = r[12];
            addr  = r[13] ? {2'b00, r[14]} : r[17:15];
            wdata = data_t'($urandom_range(0, 7));
            tick();
        end
        reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        repeat (20) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
